axil_master: RTL and testbench

AXIL_MASTER -- requirements
Module: axil_master

---
 rtl/axil_pkg.sv | 20 ++
 rtl/axil_master.sv | 218 +++++++++++++++++++++
 tb/tb_axil_master.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: master FSM states, response codes and default PROT.
package axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WAIT_B,
    ST_RD,
    ST_WAIT_R,
    ST_RESP
  } axil_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite master driven by a cmd/rsp handshake.
// Optional wait-cycle watchdog (timeout_err) built when AXIL_MASTER_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | ready for a command
// WR      | AW and W valids outstanding
// WAIT_B  | waiting for the write response
// RD      | AR valid outstanding
// WAIT_R  | waiting for read data
// RESP    | rsp_valid held until rsp_ready
module axil_master
  import axil_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int C_M_AXI_ADDR_WIDTH = 11,
  parameter int TIMEOUT_CYCLES     = 256
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESET,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_wr,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              rsp_wr,
`ifdef AXIL_MASTER_TIMEOUT_EN
  output logic                              timeout_err,
`endif
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;

  axil_state_e   state_q, state_d;
  logic          rdy_q, rdy_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          arvalid_q, arvalid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    resp_q, resp_d;
  logic          wr_q, wr_d;
  logic          accept;

  // rdy_q mirrors IDLE but stays low until the first edge out of reset
  assign accept = rdy_q & cmd_valid;

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    wr_d      = wr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d = cmd_addr;
          wr_d   = cmd_wr;
          if (cmd_wr) begin
            state_d   = ST_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
          end else begin
            state_d   = ST_RD;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_WR: begin
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY)  wvalid_d  = 1'b0;
        if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY))
          state_d = ST_WAIT_B;
      end
      ST_WAIT_B: begin
        if (M_AXI_BVALID) begin
          resp_d  = M_AXI_BRESP;
          rdata_d = '0;
          state_d = ST_RESP;
        end
      end
      ST_RD: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = ST_WAIT_R;
        end
      end
      ST_WAIT_R: begin
        if (M_AXI_RVALID) begin
          rdata_d = M_AXI_RDATA;
          resp_d  = M_AXI_RRESP;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_q   <= ST_IDLE;
      rdy_q     <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= rdy_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      wr_q      <= wr_d;
    end
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          to_err_q, to_err_d;
  logic          busy;

  // The transaction keeps waiting after the limit; only the flag is raised.
  always_comb begin
    busy     = (state_q == ST_WR) || (state_q == ST_WAIT_B) ||
               (state_q == ST_RD) || (state_q == ST_WAIT_R);
    to_cnt_d = to_cnt_q;
    to_err_d = to_err_q;
    if (accept) begin
      to_cnt_d = '0;
      to_err_d = 1'b0;
    end else begin
      if (busy && (to_cnt_q != TO_LIMIT)) to_cnt_d = to_cnt_q + TW'(1);
      if (to_cnt_d == TO_LIMIT) to_err_d = 1'b1;
    end
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
    end
  end

  assign timeout_err = to_err_q;
`endif

  assign cmd_ready     = rdy_q;
  assign rsp_valid     = (state_q == ST_RESP);
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign rsp_wr        = wr_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = PROT_DEFAULT;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = (state_q == ST_WAIT_B);
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = PROT_DEFAULT;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = (state_q == ST_WAIT_R);

endmodule

// File: tb/tb_axil_master.sv
// Directed vector bench for axil_master; timeout checks only when AXIL_MASTER_TIMEOUT_EN is defined.
module tb_axil_master;
  localparam int DW = 64;
  localparam int AW = 11;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid = 0, cmd_ready, cmd_wr = 0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic          rsp_valid, rsp_ready = 0, rsp_wr;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
`ifdef AXIL_MASTER_TIMEOUT_EN
  logic          timeout_err;
`endif
  logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]    M_AXI_AWPROT, M_AXI_ARPROT;
  logic          M_AXI_AWVALID, M_AXI_AWREADY = 0;
  logic [DW-1:0] M_AXI_WDATA;
  logic [SW-1:0] M_AXI_WSTRB;
  logic          M_AXI_WVALID, M_AXI_WREADY = 0;
  logic [1:0]    M_AXI_BRESP = 0;
  logic          M_AXI_BVALID = 0, M_AXI_BREADY;
  logic          M_AXI_ARVALID, M_AXI_ARREADY = 0;
  logic [DW-1:0] M_AXI_RDATA = '0;
  logic [1:0]    M_AXI_RRESP = 0;
  logic          M_AXI_RVALID = 0, M_AXI_RREADY;

  axil_master #(
    .C_M_AXI_DATA_WIDTH(DW),
    .C_M_AXI_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_wr(rsp_wr),
`ifdef AXIL_MASTER_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // handshake monitor, sampled on the active edge before DUT registers update
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  logic [AW-1:0] mon_awaddr, mon_araddr;
  logic [DW-1:0] mon_wdata;
  logic [SW-1:0] mon_wstrb;
  always @(posedge clk) begin
    if (!rst) begin
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin aw_hs++; mon_awaddr = M_AXI_AWADDR; end
      if (M_AXI_WVALID && M_AXI_WREADY) begin w_hs++; mon_wdata = M_AXI_WDATA; mon_wstrb = M_AXI_WSTRB; end
      if (M_AXI_BVALID && M_AXI_BREADY) b_hs++;
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin ar_hs++; mon_araddr = M_AXI_ARADDR; end
      if (M_AXI_RVALID && M_AXI_RREADY) r_hs++;
    end
  end

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    int            a_hold;    // cycle (from 1) in which AW/AR handshakes
    int            w_hold;    // cycle in which W handshakes
    int            d_wait;    // extra cycles before B/R valid
    logic [1:0]    sresp;
    logic [DW-1:0] srdata;
    int            rsp_hold;  // cycles rsp_ready is held low in RESP
    int            exp_lat;   // accept cycle counted as 1
    logic [DW-1:0] exp_rdata;
    logic [1:0]    exp_resp;
    int            exp_to;    // first cycle timeout_err is seen, 0 = never
  } vec_t;

  vec_t vecs[8];

  task automatic slave_idle();
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
    M_AXI_BVALID = 0; M_AXI_BRESP = 0;
    M_AXI_RVALID = 0; M_AXI_RRESP = 0; M_AXI_RDATA = '0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int c, resp_c, to_c, d_start, awv, wv, arv, aw0, w0, b0, ar0, r0;
    bit a_seen, w_seen, d_valid;
    logic [DW-1:0] s_rdata;
    logic [1:0] s_resp;
    logic s_wr;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    chk({tag, ".cmd_ready_idle"}, cmd_ready, 1);
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;
    cmd_valid = 1; cmd_wr = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    @(negedge clk);
    cmd_valid = 0;
    c = 1; resp_c = 0; to_c = 0; d_start = 0; awv = 0; wv = 0; arv = 0;
    while (resp_c == 0 && c < 200) begin
      slave_idle();
      if (rsp_valid) begin
        resp_c = c;
      end else begin
`ifdef AXIL_MASTER_TIMEOUT_EN
        if (c == 1) chk({tag, ".to_clear_on_accept"}, timeout_err, 0);
        if (timeout_err && to_c == 0) to_c = c;
`endif
        if (c == 1) chk({tag, ".cmd_ready_busy"}, cmd_ready, 0);
        if (M_AXI_AWVALID) awv++;
        if (M_AXI_WVALID) wv++;
        if (M_AXI_ARVALID) arv++;
        a_seen = v.wr ? (aw_hs != aw0) : (ar_hs != ar0);
        w_seen = v.wr ? (w_hs != w0) : 1'b1;
        if (a_seen && w_seen && d_start == 0) d_start = c;
        M_AXI_AWREADY = M_AXI_AWVALID && (c >= v.a_hold);
        M_AXI_WREADY  = M_AXI_WVALID && (c >= v.w_hold);
        M_AXI_ARREADY = M_AXI_ARVALID && (c >= v.a_hold);
        d_valid = (d_start != 0) && (c - d_start >= v.d_wait) &&
                  (v.wr ? (b_hs == b0) : (r_hs == r0));
        if (v.wr) begin
          M_AXI_BVALID = d_valid;
          M_AXI_BRESP  = d_valid ? v.sresp : 2'b00;
        end else begin
          M_AXI_RVALID = d_valid;
          M_AXI_RRESP  = d_valid ? v.sresp : 2'b00;
          M_AXI_RDATA  = d_valid ? v.srdata : '0;
        end
        @(negedge clk);
        c++;
      end
    end
    checks++;
    if (resp_c == 0) begin
      failures++;
      $display("FAIL %s.rsp_timeout actual=no_rsp required=rsp_valid", tag);
      return;
    end
    chk({tag, ".latency"}, resp_c + 1, v.exp_lat);
    chk({tag, ".rdata"}, rsp_rdata, v.exp_rdata);
    chk({tag, ".resp"}, rsp_resp, v.exp_resp);
    chk({tag, ".rsp_wr"}, rsp_wr, v.wr);
    if (v.wr) begin
      chk({tag, ".aw_count"}, aw_hs - aw0, 1);
      chk({tag, ".w_count"}, w_hs - w0, 1);
      chk({tag, ".b_count"}, b_hs - b0, 1);
      chk({tag, ".awvalid_cycles"}, awv, v.a_hold);
      chk({tag, ".wvalid_cycles"}, wv, v.w_hold);
      chk({tag, ".awaddr"}, mon_awaddr, v.addr);
      chk({tag, ".wdata"}, mon_wdata, v.wdata);
      chk({tag, ".wstrb"}, mon_wstrb, v.wstrb);
    end else begin
      chk({tag, ".ar_count"}, ar_hs - ar0, 1);
      chk({tag, ".r_count"}, r_hs - r0, 1);
      chk({tag, ".arvalid_cycles"}, arv, v.a_hold);
      chk({tag, ".aw_count_rd"}, aw_hs - aw0, 0);
      chk({tag, ".araddr"}, mon_araddr, v.addr);
    end
`ifdef AXIL_MASTER_TIMEOUT_EN
    chk({tag, ".timeout_cycle"}, to_c, v.exp_to);
`endif
    s_rdata = rsp_rdata; s_resp = rsp_resp; s_wr = rsp_wr;
    for (int i = 0; i < v.rsp_hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_rsp_valid"}, rsp_valid, 1);
      chk({tag, ".hold_cmd_ready"}, cmd_ready, 0);
      chk({tag, ".hold_rsp"}, {rsp_rdata, rsp_resp, rsp_wr}, {s_rdata, s_resp, s_wr});
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk({tag, ".rsp_valid_done"}, rsp_valid, 0);
    chk({tag, ".cmd_ready_back"}, cmd_ready, 1);
  endtask

  initial begin
    vecs[0] = '{1'b1, 11'h010, 64'h1122334455667788, 8'hFF, 1, 1, 0, 2'b00, 64'h0, 0, 4, 64'h0, 2'b00, 0};
    vecs[1] = '{1'b1, 11'h100, 64'hA5A5A5A55A5A5A5A, 8'h0F, 3, 1, 0, 2'b00, 64'h0, 0, 6, 64'h0, 2'b00, 0};
    vecs[2] = '{1'b1, 11'h3F0, 64'h0BADC0DE00000001, 8'h81, 1, 3, 2, 2'b10, 64'h0, 2, 8, 64'h0, 2'b10, 0};
    vecs[3] = '{1'b0, 11'h7F8, 64'h0, 8'h00, 1, 0, 0, 2'b10, 64'hDEADBEEFCAFEF00D, 0, 4, 64'hDEADBEEFCAFEF00D, 2'b10, 0};
    vecs[4] = '{1'b0, 11'h008, 64'h0, 8'h00, 2, 0, 3, 2'b11, 64'hFEDCBA9876543210, 5, 8, 64'hFEDCBA9876543210, 2'b11, 0};
    vecs[5] = '{1'b1, 11'h020, 64'h0102030405060708, 8'hF0, 2, 2, 1, 2'b01, 64'h0, 0, 6, 64'h0, 2'b01, 0};
    vecs[6] = '{1'b1, 11'h040, 64'hCCCCDDDDEEEEFFFF, 8'hFF, 1, 1, 20, 2'b00, 64'h0, 1, 24, 64'h0, 2'b00, 9};
    vecs[7] = '{1'b0, 11'h100, 64'h0, 8'h00, 1, 0, 1, 2'b00, 64'h0123456789ABCDEF, 0, 5, 64'h0123456789ABCDEF, 2'b00, 0};

    // power-on reset
    repeat (2) @(negedge clk);
    chk("por.cmd_ready", cmd_ready, 0);
    chk("por.rsp_valid", rsp_valid, 0);
    chk("por.valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 0);
    #1 rst = 0;
    #1 chk("por.cmd_ready_before_edge", cmd_ready, 0);
    @(negedge clk);
    chk("por.cmd_ready_first_edge", cmd_ready, 1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // reset while waiting for read data
    @(negedge clk);
    chk("rst.pre_cmd_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_wr = 0; cmd_addr = 11'h7F8;
    @(negedge clk);
    cmd_valid = 0;
    M_AXI_ARREADY = 1;
    @(negedge clk);
    M_AXI_ARREADY = 0;
    chk("rst.in_wait_r", M_AXI_RREADY, 1);
    #2 rst = 1;
    #1;
    chk("rst.cmd_ready", cmd_ready, 0);
    chk("rst.valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 0);
    chk("rst.readies", {M_AXI_BREADY, M_AXI_RREADY}, 0);
    chk("rst.rsp_valid", rsp_valid, 0);
    chk("rst.rsp_rdata", rsp_rdata, 0);
    chk("rst.rsp_resp_wr", {rsp_resp, rsp_wr}, 0);
    chk("rst.addr", {M_AXI_AWADDR, M_AXI_ARADDR}, 0);
    chk("rst.wdata_wstrb", {M_AXI_WDATA, M_AXI_WSTRB}, 0);
`ifdef AXIL_MASTER_TIMEOUT_EN
    chk("rst.timeout_err", timeout_err, 0);
`endif
    repeat (2) @(negedge clk);
    #1 rst = 0;
    M_AXI_RVALID = 1; M_AXI_RDATA = 64'h5555AAAA5555AAAA; M_AXI_RRESP = 2'b01;
    #1 chk("rst.cmd_ready_held", cmd_ready, 0);
    @(negedge clk);
    chk("rst.cmd_ready_rise", cmd_ready, 1);
    for (int i = 0; i < 5; i++) begin
      chk("rst.no_stale_rsp", {rsp_valid, M_AXI_RREADY}, 0);
      @(negedge clk);
    end
    slave_idle();
    run_vec(vecs[0], 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
